// File: rtl/if_id_stage_pkg.sv
// Shared definitions for the IF/ID stage and its pipeline-buffer siblings.
package if_id_stage_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefInstW = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  // A bubble is an all-zero payload, which decodes as NOP.
  localparam logic [31:0] NopInst  = ZeroWord;

  // Bit positions in the ctrl block's stall vector.
  typedef enum logic [2:0] {
    StgIf    = 3'd0,
    StgIfId  = 3'd1,
    StgIdEx  = 3'd2,
    StgExMem = 3'd3,
    StgMemWb = 3'd4
  } stage_e;

  localparam int unsigned StallIdxIfId = 1;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready pipeline register with an optional 1-entry skid slot and flush.
module pipe_skid_buf
  import if_id_stage_pkg::*;
#(
  parameter int unsigned W       = 64,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         m_valid_q, m_valid_d;
  logic [W-1:0] m_data_q, m_data_d;
  logic         s_valid_q, s_valid_d;
  logic [W-1:0] s_data_q, s_data_d;
  logic         live_q;
  logic         acc;

  // live_q keeps in_ready low until the first edge after reset.
  if (SKID_EN) begin : g_skid
    assign in_ready = live_q & ~s_valid_q;
  end else begin : g_noskid
    assign in_ready = live_q & (~m_valid_q | out_ready);
  end

  assign acc       = in_valid & in_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = '0;
      s_valid_d = 1'b0;
      s_data_d  = '0;
    end else if (!m_valid_q || out_ready) begin
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = acc;
        s_data_d  = acc ? in_data : '0;
      end else if (acc) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
      end
    end else if (acc && SKID_EN) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      live_q    <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      live_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: handshake buffer for {pc, inst} plus stall and flush control
// and a saturating held-cycle counter.
module if_id_stage
  import if_id_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned INST_W  = DefInstW,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned PayW = ADDR_W + INST_W;

  logic            adv;
  logic [PayW-1:0] out_data;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // stall from ctrl looks exactly like decode withholding out_ready.
  assign adv = out_ready & ~stall;

  pipe_skid_buf #(
    .W       (PayW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_pc, in_inst}),
    .out_valid (out_valid),
    .out_ready (adv),
    .out_data  (out_data)
  );

  assign out_pc    = out_data[PayW-1:INST_W];
  assign out_inst  = out_data[INST_W-1:0];
  assign stall_cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !adv && !flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Parametrised IF/ID pipeline stage; successor to the plain fetch/decode register.
- Adds valid/ready handshake, stall from the pipeline control block, synchronous flush for branch/exception redirect, an optional 1-entry skid buffer, and a saturating stall-cycle counter.
- Sits between the fetch PC/ROM interface and the decode stage.
- Bubbles present as all-zero payload, i.e. NOP.

Parameters:
- ADDR_W, 32, PC width in bits.
- INST_W, 32, instruction width in bits.
- SKID_EN, 1, 1 = registered in_ready with a 1-entry skid buffer; 0 = combinational in_ready, no skid.
- CNT_W, 16, stall counter width in bits.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  ADDR_W  fetched PC.
- in_inst  in  INST_W  fetched instruction.
- stall  in  1  ctrl hold request for this stage; behaves as out_ready=0.
- flush  in  1  discard all held and incoming instructions.
- out_valid  out  1  decode-side instruction valid.
- out_ready  in  1  decode consumes this cycle.
- out_pc  out  ADDR_W  PC to decode.
- out_inst  out  INST_W  instruction to decode.
- stall_cnt  out  CNT_W  saturating count of held cycles.

Behaviour:
- Reset, asynchronous, while rst=1:
  - out_valid=0; out_pc=0; out_inst=0; skid empty; stall_cnt=0.
  - in_ready=0 during reset; it is 1 on the first cycle after deassertion.
- Definitions:
  - adv = out_ready & ~stall.
  - acc = in_valid & in_ready.
  - Main register M = {out_valid, out_pc, out_inst}.
  - Skid register S = {s_valid, s_pc, s_inst}.
- Latency 1 cycle from acc to out_valid; throughput 1 instruction/cycle when adv is held high.
- in_ready:
  - SKID_EN=1: in_ready = ~s_valid, from a register, with no combinational path from out_ready or stall.
  - SKID_EN=0: in_ready = ~out_valid | adv.
- Priority 1, flush=1: next out_valid=0, s_valid=0, payloads zeroed. An instruction accepted that same cycle is dropped. Flush overrides stall.
- Priority 2, M empty or adv=1, M refill source:
  - S if s_valid, then s_valid<=0, and any acc this cycle is written into S;
  - else input if acc;
  - else bubble: out_valid=0, out_pc=0, out_inst=0.
- Priority 3, M valid and adv=0:
  - M holds; outputs stable, no change while held.
  - acc writes S (SKID_EN=1 only).
  - acc while s_valid=1 cannot occur because in_ready=0.
- Ordering: instructions leave in strict arrival order, never duplicated. One accepted per acc, one consumed per out_valid&adv.
- Boundary cases:
  - Both M and S full: in_ready=0.
  - Simultaneous adv and acc with S full: S→M and input→S in the same edge.
  - stall=1 with out_valid=0: M may still fill from input (no bubble retention).
- stall_cnt:
  - Increments by 1 on each edge where out_valid=1 & adv=0 & flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by rst.
- Reset mid-operation: all contents lost immediately, no partial update on the following edge.

Decomposition:
- Shared package/defines: ZeroWord, NOP encoding, default ADDR_W/INST_W.
- Stall-vector bit index for the IF/ID stage, used by the ctrl block to drive stall.
- Natural sub-module: pipe_skid_buf, a generic payload-width 2-slot register with valid/ready. if_id_stage instantiates it with payload {pc, inst} and adds flush and stall_cnt.
- The same buffer is reusable for id_ex and ex_mem successors.

Test Plan:
- Streaming:
  - Stimulus: rst 3 cycles; then in_valid=1 with pc 0x0,0x4,0x8,0xC, inst 0x34011100.., out_ready=1, stall=0.
  - Required: out_pc sequence 0x0..0xC one cycle later, back-to-back; stall_cnt=0.
- Stall with skid:
  - Stimulus: streaming as above, stall=1 for 3 cycles starting while pc 0x4 is on the output.
  - Required: out_pc held at 0x4; 0x8 captured in S; in_ready=0 after one cycle; on release outputs 0x8, 0xC with no loss; stall_cnt=3.
- Flush during stall:
  - Stimulus: M=0x10, S=0x14, flush=1 with in_valid=1 pc 0x18.
  - Required: next cycle out_valid=0, out_pc=0, out_inst=0; 0x18 dropped; next accepted pc appears normally.
- Async reset mid-stream:
  - Stimulus: rst asserted between clock edges while M and S are full.
  - Required: outputs zero immediately, before next edge; in_ready=0 during rst, 1 after.
- SKID_EN=0:
  - Stimulus: out_ready toggles 1,0,1 each cycle.
  - Required: in_ready equals ~out_valid|adv combinationally; order preserved; no payload change while held.
- Counter saturation:
  - Stimulus: CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles.
  - Required: stall_cnt reaches 15 and stays at 15.
